dma_mem_responder: RTL and testbench
====================================

Name: dma_mem_responder

Overview:
- Memory-side responder for the DMA engine's burst read and write request channels; serves bursts from a single-port synchronous SRAM.
- Sits between the DMA engine core and an on-chip data RAM.
- Accepts one burst at a time, either read or write, and arbitrates between them round-robin.
- Responds beat-by-beat with valid/ready handshakes on both data channels.

Parameters:
- MEM_AW, 16, SRAM word-address width (SRAM depth = 2^MEM_AW 32-bit words)
- DATA_WIDTH, 32, data width; only 32 is supported

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, asynchronous, active-high
- rd_req_addr  in  32  read burst start byte address (word aligned)
- rd_req_len  in  5  read burst beats minus 1
- rd_req_valid  in  1  read request valid
- rd_req_ready  out  1  read request accepted
- rd_rdata  out  32  read beat data
- rd_valid  out  1  read beat valid
- rd_last  out  1  final read beat
- rd_ready  in  1  engine accepts read beat
- wr_req_addr  in  32  write burst start byte address
- wr_req_len  in  5  write burst beats minus 1
- wr_req_valid  in  1  write request valid
- wr_req_ready  out  1  write request accepted
- wr_data  in  32  write beat data
- wr_valid  in  1  write beat valid
- wr_last  in  1  final write beat
- wr_ready  out  1  responder accepts write beat
- mem_addr  out  MEM_AW  SRAM word address
- mem_wdata  out  32  SRAM write data
- mem_wen  out  1  SRAM write strobe
- mem_ren  out  1  SRAM read strobe; data is on mem_rdata the next cycle
- mem_rdata  in  32  SRAM read data
- err  out  1  sticky protocol error flag

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE; all outputs 0; err = 0; round-robin pointer = read.
  - Internal addr, beat counter and len registers cleared.
  - A burst in flight is abandoned; no further mem_wen.
- States: IDLE, RD_ISSUE, RD_DATA, WR_DATA.
- IDLE arbitration:
  - Only one request valid: grant it.
  - Both valid: grant the channel not granted last. Pointer starts at read, so read wins the first tie.
  - rd_req_ready = (IDLE && rd_req_valid && grant_rd). wr_req_ready is the analogous signal for the write channel. Both are combinational, never high together, and low outside IDLE.
  - On the handshake, latch addr and len and clear the beat counter (5 bit).
  - Next state: read grant -> RD_ISSUE; write grant -> WR_DATA.
- RD_ISSUE (one cycle):
  - mem_ren = 1, mem_addr = addr[MEM_AW+1:2].
  - Always goes to RD_DATA.
- RD_DATA:
  - On entry, rd_rdata is registered from mem_rdata; rd_valid = 1.
  - rd_rdata and rd_valid hold stable until rd_ready is seen.
  - rd_last = rd_valid && (beat == len).
  - On handshake, if last -> IDLE; else addr += 4, beat += 1 -> RD_ISSUE.
  - Throughput is 1 beat per 2 cycles minimum. First data appears 2 cycles after the request handshake.
- WR_DATA:
  - wr_ready = 1.
  - On wr_valid, same cycle: mem_wen = 1, mem_addr = addr[MEM_AW+1:2], mem_wdata = wr_data. Then addr += 4, beat += 1.
  - If beat == len on the handshake: wr_last must be 1; go to IDLE. If wr_last = 0 there, set err and still go to IDLE.
  - If wr_last = 1 on a beat with beat < len: write that beat, set err, go to IDLE (early termination).
- Address arithmetic:
  - addr is 32 bit and wraps modulo 2^32.
  - mem_addr uses only the low bits, so a burst wraps around SRAM depth with no error.
  - addr[1:0] != 0 at request: set err and force addr[1:0] to 0.
- mem_wen and mem_ren are never high together. Each fires only in its own state.
- One request is accepted per IDLE cycle. After a burst completes, IDLE is re-entered for at least one cycle before the next grant.
- Write beats presented while not in WR_DATA are ignored (wr_ready = 0).
- err is sticky until reset.

Test Plan:
- Read burst: SRAM word i preloaded with 0xA000_0000+i; rd_req addr 0x100, len 7, rd_ready=1 -> 8 beats 0xA000_0040..0xA000_0047 every 2 cycles; rd_last only on the 8th beat; then back to IDLE; err=0.
- Read backpressure: same burst with rd_ready low for 3 cycles on beat 3 -> rd_rdata/rd_valid stable during the stall; no extra mem_ren; sequence unchanged.
- Write burst: wr_req addr 0x200, len 7; data 0x5500+k, with wr_valid gapped every other cycle -> mem_wen exactly 8 times at words 0x80..0x87; readback via read burst matches; err=0.
- Simultaneous requests: rd and wr valid in the same cycle, twice -> first grant read, second grant write, both complete correctly.
- Protocol error: write len 7 with wr_last on beat 3 -> 4 mem writes, IDLE, err=1 held until reset; also a write at address 0xFFFF_FFFC on a 16-bit SRAM wraps to word 0 without error.
- Reset mid-burst: assert rst asynchronously during RD_DATA beat 2 -> outputs 0 immediately; after release a new read burst completes correctly.

Source files
------------

// File: rtl/dma_mem_responder.sv
// Memory-side responder for DMA burst read/write requests, serving one burst
// at a time from a single-port synchronous SRAM with round-robin arbitration.
module dma_mem_responder #(
    parameter int unsigned MEM_AW     = 16,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           rd_req_addr,
    input  logic [4:0]            rd_req_len,
    input  logic                  rd_req_valid,
    output logic                  rd_req_ready,
    output logic [DATA_WIDTH-1:0] rd_rdata,
    output logic                  rd_valid,
    output logic                  rd_last,
    input  logic                  rd_ready,
    input  logic [31:0]           wr_req_addr,
    input  logic [4:0]            wr_req_len,
    input  logic                  wr_req_valid,
    output logic                  wr_req_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    input  logic                  wr_last,
    output logic                  wr_ready,
    output logic [MEM_AW-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wen,
    output logic                  mem_ren,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  err
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LEN_W  = 5;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_RD_ISSUE = 2'd1;
    localparam logic [1:0] S_RD_DATA  = 2'd2;
    localparam logic [1:0] S_WR_DATA  = 2'd3;

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [ADDR_W-1:0]     addr;
    logic [LEN_W-1:0]      len;
    logic [LEN_W-1:0]      beat;
    logic                  prefer_wr;
    logic                  rd_first;
    logic [DATA_WIDTH-1:0] rd_hold;
    logic                  grant_rd;
    logic                  grant_wr;
    logic                  rd_hs;
    logic                  wr_hs;
    logic                  at_last;

    assign at_last  = (beat == len);
    assign rd_last  = rd_valid && at_last;
    assign mem_addr = addr[MEM_AW+1:2];
    // SRAM data is live in the first data cycle; afterwards the captured copy holds it stable.
    assign rd_rdata = rd_first ? mem_rdata : rd_hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Arbitration, handshakes and SRAM strobes.
    always_comb begin
        state_nxt    = state;
        grant_rd     = 1'b0;
        grant_wr     = 1'b0;
        rd_req_ready = 1'b0;
        wr_req_ready = 1'b0;
        wr_ready     = 1'b0;
        mem_ren      = 1'b0;
        mem_wen      = 1'b0;
        mem_wdata    = '0;
        rd_hs        = 1'b0;
        wr_hs        = 1'b0;
        case (state)
            S_IDLE: begin
                grant_rd     = rd_req_valid && (!wr_req_valid || !prefer_wr);
                grant_wr     = wr_req_valid && !grant_rd;
                rd_req_ready = grant_rd;
                wr_req_ready = grant_wr;
                if (grant_rd) begin
                    state_nxt = S_RD_ISSUE;
                end else if (grant_wr) begin
                    state_nxt = S_WR_DATA;
                end
            end
            S_RD_ISSUE: begin
                mem_ren   = 1'b1;
                state_nxt = S_RD_DATA;
            end
            S_RD_DATA: begin
                rd_hs = rd_valid && rd_ready;
                if (rd_hs) begin
                    state_nxt = at_last ? S_IDLE : S_RD_ISSUE;
                end
            end
            S_WR_DATA: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    wr_hs     = 1'b1;
                    mem_wen   = 1'b1;
                    mem_wdata = wr_data;
                    if (at_last || wr_last) begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr      <= '0;
            len       <= '0;
            beat      <= '0;
            prefer_wr <= 1'b0;
            err       <= 1'b0;
            rd_valid  <= 1'b0;
            rd_first  <= 1'b0;
            rd_hold   <= '0;
        end else begin
            if (rd_req_ready) begin
                addr      <= {rd_req_addr[ADDR_W-1:2], 2'b00};
                len       <= rd_req_len;
                beat      <= '0;
                prefer_wr <= 1'b1;
                if (rd_req_addr[1:0] != 2'b00) err <= 1'b1;
            end
            if (wr_req_ready) begin
                addr      <= {wr_req_addr[ADDR_W-1:2], 2'b00};
                len       <= wr_req_len;
                beat      <= '0;
                prefer_wr <= 1'b0;
                if (wr_req_addr[1:0] != 2'b00) err <= 1'b1;
            end
            if (state == S_RD_ISSUE) begin
                rd_valid <= 1'b1;
                rd_first <= 1'b1;
            end
            if (rd_first) begin
                rd_hold  <= mem_rdata;
                rd_first <= 1'b0;
            end
            if (rd_hs) begin
                rd_valid <= 1'b0;
                if (!at_last) begin
                    addr <= addr + 32'd4;
                    beat <= beat + 5'd1;
                end
            end
            // A write burst must end with wr_last exactly on its final beat.
            if (wr_hs) begin
                addr <= addr + 32'd4;
                beat <= beat + 5'd1;
                if (at_last != wr_last) err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dma_mem_responder.sv
// Directed bench for dma_mem_responder with a behavioural SRAM whose
// unwritten words read as 0xA000_0000 + word index.
module tb_dma_mem_responder;

    localparam int unsigned MEM_AW = 16;

    logic              clk;
    logic              rst;
    logic [31:0]       rd_req_addr;
    logic [4:0]        rd_req_len;
    logic              rd_req_valid;
    logic              rd_req_ready;
    logic [31:0]       rd_rdata;
    logic              rd_valid;
    logic              rd_last;
    logic              rd_ready;
    logic [31:0]       wr_req_addr;
    logic [4:0]        wr_req_len;
    logic              wr_req_valid;
    logic              wr_req_ready;
    logic [31:0]       wr_data;
    logic              wr_valid;
    logic              wr_last;
    logic              wr_ready;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_wen;
    logic              mem_ren;
    logic [31:0]       mem_rdata;
    logic              err;

    int n_vec = 0;
    int n_bad = 0;
    int wen_cnt = 0;
    int ren_cnt = 0;
    int both_cnt = 0;

    logic [31:0] mem [0:65535];
    bit          written [0:65535];

    dma_mem_responder #(.MEM_AW(MEM_AW), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_rdata(rd_rdata), .rd_valid(rd_valid), .rd_last(rd_last),
        .rd_ready(rd_ready),
        .wr_req_addr(wr_req_addr), .wr_req_len(wr_req_len),
        .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_last(wr_last),
        .wr_ready(wr_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
        .mem_ren(mem_ren), .mem_rdata(mem_rdata), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (mem_wen) begin
            mem[mem_addr]     <= mem_wdata;
            written[mem_addr] <= 1'b1;
            wen_cnt           <= wen_cnt + 1;
        end
        if (mem_ren) begin
            mem_rdata <= written[mem_addr] ? mem[mem_addr] : 32'hA000_0000 + 32'(mem_addr);
            ren_cnt   <= ren_cnt + 1;
        end
        if (mem_wen && mem_ren) both_cnt <= both_cnt + 1;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Called at a falling edge in IDLE; returns at the falling edge after the burst.
    task automatic rd_burst(input logic [31:0] a, input logic [4:0] l, input int stall_beat,
                            input int stall_n, input logic [31:0] d0, input bit tie);
        int r0;
        r0 = ren_cnt;
        rd_req_addr  = a;
        rd_req_len   = l;
        rd_req_valid = 1'b1;
        rd_ready     = 1'b1;
        #1;
        chk1("rd_req_ready", rd_req_ready, 1'b1);
        if (tie) chk1("wr_req_ready_tie", wr_req_ready, 1'b0);
        @(negedge clk);
        rd_req_valid = 1'b0;
        for (int k = 0; k <= int'(l); k++) begin
            if (k > 0) @(negedge clk);
            chk1("mem_ren_issue", mem_ren, 1'b1);
            chk1("wr_req_ready_busy", wr_req_ready, 1'b0);
            chk("mem_addr_rd", 32'(mem_addr), 32'(16'((a >> 2) + 32'(k))));
            @(negedge clk);
            chk1("rd_valid", rd_valid, 1'b1);
            chk("rd_rdata", rd_rdata, d0 + 32'(k));
            chk1("rd_last", rd_last, k == int'(l));
            if (k == stall_beat) begin
                rd_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    @(negedge clk);
                    chk1("rd_valid_stall", rd_valid, 1'b1);
                    chk("rd_rdata_stall", rd_rdata, d0 + 32'(k));
                    chk1("mem_ren_stall", mem_ren, 1'b0);
                end
                rd_ready = 1'b1;
            end
        end
        @(negedge clk);
        chk1("rd_valid_idle", rd_valid, 1'b0);
        chk1("mem_ren_idle", mem_ren, 1'b0);
        chk("rd_ren_count", 32'(ren_cnt - r0), 32'(int'(l) + 1));
    endtask

    // Called at a falling edge in IDLE; early >= 0 raises wr_last on that beat.
    task automatic wr_burst(input logic [31:0] a, input logic [4:0] l, input bit gap,
                            input int early, input logic [31:0] d0, input bit tie);
        int w0;
        int nb;
        nb = (early >= 0) ? early + 1 : int'(l) + 1;
        w0 = wen_cnt;
        wr_req_addr  = a;
        wr_req_len   = l;
        wr_req_valid = 1'b1;
        if (tie) begin
            rd_req_addr  = 32'h0;
            rd_req_len   = 5'd0;
            rd_req_valid = 1'b1;
        end
        #1;
        chk1("wr_req_ready", wr_req_ready, 1'b1);
        if (tie) chk1("rd_req_ready_tie", rd_req_ready, 1'b0);
        @(negedge clk);
        wr_req_valid = 1'b0;
        rd_req_valid = 1'b0;
        for (int k = 0; k < nb; k++) begin
            wr_valid = 1'b1;
            wr_data  = d0 + 32'(k);
            wr_last  = (k == nb - 1);
            #1;
            chk1("wr_ready", wr_ready, 1'b1);
            chk1("mem_wen", mem_wen, 1'b1);
            chk("mem_addr_wr", 32'(mem_addr), 32'(16'((a >> 2) + 32'(k))));
            chk("mem_wdata", mem_wdata, d0 + 32'(k));
            @(negedge clk);
            wr_valid = 1'b0;
            wr_last  = 1'b0;
            if (gap && k < nb - 1) begin
                #1;
                chk1("mem_wen_gap", mem_wen, 1'b0);
                @(negedge clk);
            end
        end
        #1;
        chk1("wr_ready_idle", wr_ready, 1'b0);
        chk("wr_wen_count", 32'(wen_cnt - w0), 32'(nb));
    endtask

    initial begin
        rst          = 1'b1;
        rd_req_addr  = '0;
        rd_req_len   = '0;
        rd_req_valid = 1'b0;
        rd_ready     = 1'b1;
        wr_req_addr  = '0;
        wr_req_len   = '0;
        wr_req_valid = 1'b0;
        wr_data      = '0;
        wr_valid     = 1'b0;
        wr_last      = 1'b0;

        repeat (2) @(negedge clk);
        chk1("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_rdata", rd_rdata, 32'h0);
        chk1("rst_mem_wen", mem_wen, 1'b0);
        chk1("rst_mem_ren", mem_ren, 1'b0);
        chk1("rst_wr_ready", wr_ready, 1'b0);
        chk1("rst_err", err, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Stray write beat in IDLE is not accepted.
        wr_valid = 1'b1;
        #1;
        chk1("idle_wr_ready", wr_ready, 1'b0);
        chk1("idle_mem_wen", mem_wen, 1'b0);
        wr_valid = 1'b0;
        @(negedge clk);

        rd_burst(32'h100, 5'd7, -1, 0, 32'hA000_0040, 1'b0);
        chk1("rd_err", err, 1'b0);
        @(negedge clk);
        rd_burst(32'h100, 5'd7, 3, 3, 32'hA000_0040, 1'b0);
        @(negedge clk);
        wr_burst(32'h200, 5'd7, 1'b1, -1, 32'h5500, 1'b0);
        chk1("wr_err", err, 1'b0);
        @(negedge clk);

        // Tie after a write grant goes to read, the following tie to write.
        wr_req_addr  = 32'h300;
        wr_req_len   = 5'd3;
        wr_req_valid = 1'b1;
        rd_burst(32'h200, 5'd7, -1, 0, 32'h5500, 1'b1);
        wr_burst(32'h300, 5'd3, 1'b0, -1, 32'h6600, 1'b1);
        @(negedge clk);
        rd_burst(32'h300, 5'd3, -1, 0, 32'h6600, 1'b0);

        @(negedge clk);
        wr_burst(32'hFFFF_FFFC, 5'd1, 1'b0, -1, 32'h7700, 1'b0);
        @(negedge clk);
        rd_burst(32'hFFFF_FFFC, 5'd1, -1, 0, 32'h7700, 1'b0);
        chk1("wrap_err", err, 1'b0);

        @(negedge clk);
        wr_burst(32'h400, 5'd7, 1'b0, 3, 32'h8800, 1'b0);
        chk1("early_err", err, 1'b1);
        repeat (3) @(negedge clk);
        chk1("early_err_sticky", err, 1'b1);

        // Asynchronous reset while beat 2 of a read burst is presented.
        rd_req_addr  = 32'h100;
        rd_req_len   = 5'd7;
        rd_req_valid = 1'b1;
        rd_ready     = 1'b1;
        @(negedge clk);
        rd_req_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk1("mid_rd_valid", rd_valid, 1'b1);
        chk("mid_rd_rdata", rd_rdata, 32'hA000_0042);
        #2;
        rst = 1'b1;
        #1;
        chk1("arst_rd_valid", rd_valid, 1'b0);
        chk("arst_rd_rdata", rd_rdata, 32'h0);
        chk1("arst_rd_last", rd_last, 1'b0);
        chk1("arst_mem_ren", mem_ren, 1'b0);
        chk1("arst_err", err, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rd_burst(32'h40, 5'd3, -1, 0, 32'hA000_0010, 1'b0);
        chk1("post_rst_err", err, 1'b0);
        chk("wen_ren_overlap", 32'(both_cnt), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
